load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory-stage sequencer between execute and data_memory. Accepts one load/store
//   request per valid/ready handshake, forms effective address, checks legality,
//   drives data_memory control for exactly one cycle, captures registered read data,
//   returns result + dest tag to writeback over a valid/ready response channel.
// PARAMETERS
//   ADDR_W  8   data_memory address width (mem_addr width)
//   DATA_W  32  data width
//   TAG_W   5   destination register tag width
// PORTS
//   clk                  in   1       single clock, rising edge
//   reset                in   1       synchronous, active-high
//   req_valid            in   1       request present
//   req_ready            out  1       LSU can accept (high only in IDLE)
//   req_we               in   1       1 = store, 0 = load
//   req_funct3           in   3       RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_base             in   DATA_W  base register value
//   req_offset           in   DATA_W  sign-extended immediate
//   req_wdata            in   DATA_W  store data
//   req_rd               in   TAG_W   load destination tag
//   resp_valid           out  1       response present
//   resp_ready           in   1       writeback accepts response
//   resp_rdata           out  DATA_W  load result (0 for stores/errors)
//   resp_rd              out  TAG_W   tag of completed request
//   resp_err             out  1       illegal / out-of-range / misaligned
//   mem_addr             out  ADDR_W  to data_memory addr
//   mem_write_data       out  DATA_W  to data_memory write_data
//   mem_read, mem_write  out  1 each  to data_memory strobes
//   mem_signed_unsigned  out  1       1 = unsigned load
//   mem_size             out  2       01 byte, 10 half, 11 word
//   mem_read_data        in   DATA_W  from data_memory read_data (registered there)
// BEHAVIOUR
//   - Reset (sync): state=IDLE; req_ready=1 after reset edge; resp_valid=0,
//     resp_rdata=0, resp_rd=0, resp_err=0; all mem_* outputs 0. Reset mid-op aborts
//     immediately, strobes drop at that edge, pending response discarded.
//   - All outputs registered. States: IDLE, ISSUE, CAPTURE, RESP.
//   - IDLE: req_valid & req_ready -> latch eff=req_base+req_offset (32b, wraps mod 2^32),
//     funct3, wdata, rd. Illegal funct3 (load 011/110/111, store 1xx/011), eff[31:ADDR_W]!=0,
//     or trap (see CONFIGURATION) -> RESP with resp_err=1, no memory access; else -> ISSUE.
//   - ISSUE (1 cycle): exactly one of mem_read/mem_write=1; mem_addr=eff[ADDR_W-1:0];
//     mem_size from funct3[1:0] (00->01, 01->10, 10->11); mem_signed_unsigned=funct3[2]
//     for loads, 0 for stores; mem_write_data=req_wdata unmodified (memory truncates).
//     Load -> CAPTURE; store -> RESP.
//   - CAPTURE: strobes 0; sample mem_read_data into resp_rdata -> RESP.
//   - RESP: resp_valid=1, payload stable until resp_valid&resp_ready; then IDLE,
//     resp_valid=0 next cycle. Back-to-back: new request only after return to IDLE.
//   - Latency from accept edge: load resp_valid on 3rd edge, store on 2nd, error on 1st.
//   - Strobes never high outside ISSUE; never both high.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: half with eff[0]=1, word with eff[1:0]!=0 -> resp_err=1,
//     no access. Undefined: no alignment check; access issued at eff as-is.
// TESTING
//   - LW base=0x10 off=0x4, memory[0x14]=0xDEADBEEF -> one mem_read pulse addr 0x14 size 11,
//     resp_rdata=0xDEADBEEF, err=0, resp_valid 3 edges after accept.
//   - LB vs LBU at addr 0x20 holding 0x000000F0 -> 0xFFFFFFF0 then 0x000000F0;
//     mem_signed_unsigned 0 then 1.
//   - SH wdata=0x12345678 addr 0x08 -> mem_write one cycle, size 10, resp_valid 2 edges
//     later, resp_rdata=0; following LHU addr 0x08 -> 0x00005678.
//   - base=0x100 off=0 or funct3=011 -> resp_err=1 next edge, mem_read/mem_write never high;
//     LW addr 0x02: err=1 with MISALIGN_TRAP_EN, else access issued at 0x02.
//   - Hold resp_ready=0 for 5 cycles -> resp_valid/payload stable, req_ready=0,
//     no new strobes; release -> IDLE next cycle.
//   - Assert reset during ISSUE of a store -> mem_write=0 after reset edge, resp_valid stays 0,
//     req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer: one request per handshake, one-cycle memory strobe,
// registered response. Optional alignment trap enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [DATA_W-1:0] req_base_i,
    input  logic [DATA_W-1:0] req_offset_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [TAG_W-1:0]  req_rd_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic [TAG_W-1:0]  resp_rd_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_signed_unsigned_o,
    output logic [1:0]        mem_size_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e state_q, state_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [TAG_W-1:0]  resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_su_q, mem_su_d;
    logic [1:0]        mem_size_q, mem_size_d;

    logic [DATA_W-1:0] eff;
    logic              accept;
    logic              f3_bad;
    logic              range_bad;
    logic              align_bad;
    logic              req_err;

    // Request decode, evaluated on the raw inputs during the accept cycle.
    always_comb begin
        eff       = req_base_i + req_offset_i;
        accept    = req_valid_i & req_ready_q;
        if (req_we_i) begin
            f3_bad = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        end else begin
            f3_bad = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i == 3'b110);
        end
        range_bad = |eff[DATA_W-1:ADDR_W];
`ifdef MISALIGN_TRAP_EN
        align_bad = ((req_funct3_i[1:0] == 2'b01) & eff[0]) |
                    ((req_funct3_i[1:0] == 2'b10) & (eff[1:0] != 2'b00));
`else
        align_bad = 1'b0;
`endif
        req_err   = f3_bad | range_bad | align_bad;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_su_q     <= 1'b0;
            mem_size_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_su_q     <= mem_su_d;
            mem_size_q   <= mem_size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = req_err ? StResp : StIssue;
            StIssue:   state_d = mem_read_q ? StCapture : StResp;
            StCapture: state_d = StResp;
            StResp:    if (resp_ready_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output registers load the values that belong to the state being entered.
    always_comb begin
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_su_d     = mem_su_q;
        mem_size_d   = mem_size_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready_d  = 1'b0;
                    resp_rd_d    = req_rd_i;
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    resp_valid_d = req_err;
                    if (!req_err) begin
                        mem_read_d  = ~req_we_i;
                        mem_write_d = req_we_i;
                        mem_addr_d  = eff[ADDR_W-1:0];
                        mem_wdata_d = req_wdata_i;
                        mem_su_d    = ~req_we_i & req_funct3_i[2];
                        mem_size_d  = req_funct3_i[1:0] + 2'd1;
                    end
                end
            end
            StIssue: begin
                if (!mem_read_q) resp_valid_d = 1'b1;
            end
            StCapture: begin
                resp_rdata_d = mem_read_data_i;
                resp_valid_d = 1'b1;
            end
            StResp: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready_o           = req_ready_q;
    assign resp_valid_o          = resp_valid_q;
    assign resp_rdata_o          = resp_rdata_q;
    assign resp_rd_o             = resp_rd_q;
    assign resp_err_o            = resp_err_q;
    assign mem_addr_o            = mem_addr_q;
    assign mem_write_data_o      = mem_wdata_q;
    assign mem_read_o            = mem_read_q;
    assign mem_write_o           = mem_write_q;
    assign mem_signed_unsigned_o = mem_su_q;
    assign mem_size_o            = mem_size_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed registered data memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_base = '0;
    logic [31:0] req_offset = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_su;
    logic [1:0]  mem_size;
    logic [31:0] mem_read_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .DATA_W(32), .TAG_W(5)) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_we_i              (req_we),
        .req_funct3_i          (req_funct3),
        .req_base_i            (req_base),
        .req_offset_i          (req_offset),
        .req_wdata_i           (req_wdata),
        .req_rd_i              (req_rd),
        .resp_valid_o          (resp_valid),
        .resp_ready_i          (resp_ready),
        .resp_rdata_o          (resp_rdata),
        .resp_rd_o             (resp_rd),
        .resp_err_o            (resp_err),
        .mem_addr_o            (mem_addr),
        .mem_write_data_o      (mem_write_data),
        .mem_read_o            (mem_read),
        .mem_write_o           (mem_write),
        .mem_signed_unsigned_o (mem_su),
        .mem_size_o            (mem_size),
        .mem_read_data_i       (mem_read_data)
    );

    // Data memory model: little-endian bytes, read data registered, extension done here.
    logic [7:0] mem_b [256];

    function automatic logic [31:0] mem_rd(input logic [7:0] a, input logic [1:0] sz,
                                           input logic us);
        logic [31:0] w;
        w = {mem_b[8'(a + 8'd3)], mem_b[8'(a + 8'd2)], mem_b[8'(a + 8'd1)], mem_b[a]};
        case (sz)
            2'b01:   mem_rd = us ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'b10:   mem_rd = us ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: mem_rd = w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= (i < 8) ? 8'(i) : 8'h00;
            mem_b[8'h14] <= 8'hEF;
            mem_b[8'h15] <= 8'hBE;
            mem_b[8'h16] <= 8'hAD;
            mem_b[8'h17] <= 8'hDE;
            mem_b[8'h20] <= 8'hF0;
        end else if (mem_write) begin
            mem_b[mem_addr] <= mem_write_data[7:0];
            if (mem_size != 2'b01) mem_b[8'(mem_addr + 8'd1)] <= mem_write_data[15:8];
            if (mem_size == 2'b11) begin
                mem_b[8'(mem_addr + 8'd2)] <= mem_write_data[23:16];
                mem_b[8'(mem_addr + 8'd3)] <= mem_write_data[31:24];
            end
        end
        if (mem_read) mem_read_data <= mem_rd(mem_addr, mem_size, mem_su);
    end

    // Strobe monitor, sampled mid-cycle.
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic       both_seen = 1'b0;
    logic       long_seen = 1'b0;
    logic       strobe_prev = 1'b0;
    logic [7:0] last_addr = '0;
    logic [1:0] last_size = '0;
    logic       last_su = 1'b0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (mem_read && mem_write) both_seen <= 1'b1;
        if ((mem_read || mem_write) && strobe_prev) long_seen <= 1'b1;
        strobe_prev <= mem_read | mem_write;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= mem_write_data;
        end
        if (mem_read || mem_write) begin
            last_addr <= mem_addr;
            last_size <= mem_size;
            last_su   <= mem_su;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request, return edges from the accept edge (counted as 1) to resp_valid.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                          output int lat);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_base = base; req_offset = off;
        req_wdata = wd; req_rd = rd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int r0;
        int w0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_rd", 32'(resp_rd), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem", {mem_read, mem_write, mem_su, mem_size, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // LW 0x10+0x4
        do_req(1'b0, 3'b010, 32'h10, 32'h4, 32'h0, 5'd5, lat);
        check("lw_lat", 32'(lat), 32'd3);
        check("lw_rdata", resp_rdata, 32'hDEADBEEF);
        check("lw_err", 32'(resp_err), 32'd0);
        check("lw_rd", 32'(resp_rd), 32'd5);
        check("lw_rdcnt", 32'(rd_cnt), 32'd1);
        check("lw_addr", 32'(last_addr), 32'h14);
        check("lw_size", 32'(last_size), 32'd3);
        take("lw");

        // LB at 0x20, base+offset wraps mod 2^32
        do_req(1'b0, 3'b000, 32'h30, 32'hFFFF_FFF0, 32'h0, 5'd6, lat);
        check("lb_lat", 32'(lat), 32'd3);
        check("lb_rdata", resp_rdata, 32'hFFFF_FFF0);
        check("lb_su", 32'(last_su), 32'd0);
        check("lb_addr", 32'(last_addr), 32'h20);
        take("lb");

        do_req(1'b0, 3'b100, 32'h20, 32'h0, 32'h0, 5'd7, lat);
        check("lbu_rdata", resp_rdata, 32'h0000_00F0);
        check("lbu_su", 32'(last_su), 32'd1);
        check("lbu_size", 32'(last_size), 32'd1);
        take("lbu");

        // SH then LHU at 0x08
        w0 = wr_cnt;
        do_req(1'b1, 3'b001, 32'h08, 32'h0, 32'h1234_5678, 5'd8, lat);
        check("sh_lat", 32'(lat), 32'd2);
        check("sh_rdata", resp_rdata, 32'd0);
        check("sh_err", 32'(resp_err), 32'd0);
        check("sh_wrcnt", 32'(wr_cnt - w0), 32'd1);
        check("sh_size", 32'(last_size), 32'd2);
        check("sh_su", 32'(last_su), 32'd0);
        check("sh_wdata", last_wdata, 32'h1234_5678);
        take("sh");

        do_req(1'b0, 3'b101, 32'h0, 32'h08, 32'h0, 5'd9, lat);
        check("lhu_rdata", resp_rdata, 32'h0000_5678);
        take("lhu");

        // Errors: no memory access, response on the accept edge
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd10, lat);
        check("oor_lat", 32'(lat), 32'd1);
        check("oor_err", 32'(resp_err), 32'd1);
        check("oor_rdata", resp_rdata, 32'd0);
        check("oor_rd", 32'(resp_rd), 32'd10);
        take("oor");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd11, lat);
        check("f3ld_lat", 32'(lat), 32'd1);
        check("f3ld_err", 32'(resp_err), 32'd1);
        take("f3ld");
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd12, lat);
        check("f3st_lat", 32'(lat), 32'd1);
        check("f3st_err", 32'(resp_err), 32'd1);
        take("f3st");
        check("err_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

        // Misaligned word at 0x02
        r0 = rd_cnt;
        do_req(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 5'd13, lat);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(resp_err), 32'd1);
        check("mis_rdcnt", 32'(rd_cnt - r0), 32'd0);
`else
        check("mis_lat", 32'(lat), 32'd3);
        check("mis_err", 32'(resp_err), 32'd0);
        check("mis_addr", 32'(last_addr), 32'h02);
        check("mis_rdata", resp_rdata, 32'h0504_0302);
`endif
        take("mis");

        // Backpressure: response held 5 cycles, competing store must not be accepted
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 5'd14, lat);
        check("bp_lat", 32'(lat), 32'd3);
        r0 = rd_cnt; w0 = wr_cnt;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_base = 32'h40; req_offset = 32'h0;
        req_wdata = 32'hCAFE_F00D; req_rd = 5'd15; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'hDEADBEEF);
            check("bp_rd", 32'(resp_rd), 32'd14);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check("bp_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        take("bp");

        // Reset while a store is in ISSUE
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_base = 32'h30; req_offset = 32'h0;
        req_wdata = 32'h1111_2222; req_rd = 5'd16; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rsti_we_high", 32'(mem_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rsti_we_low", 32'(mem_write), 32'd0);
        check("rsti_valid", 32'(resp_valid), 32'd0);
        check("rsti_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rsti_valid_after", 32'(resp_valid), 32'd0);
        check("rsti_ready_after", 32'(req_ready), 32'd1);

        check("never_both", 32'(both_seen), 32'd0);
        check("single_cycle_strobe", 32'(long_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
